conv_addr_gen: RTL and testbench

//  Parametrised successor of the convolution feature-address sequencer. Walks output tiles, rows, kernel taps,

---
 rtl/conv_addr_gen.sv | 198 +++++++++++++++++++
 tb/tb_conv_addr_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_addr_gen.sv
// Convolution feature-address sequencer: walks ct/oh/ky/kx/ci/ow and emits one feature
// coordinate per valid/ready beat, with stride, dilation, padding flag and depthwise mode.
module conv_addr_gen #(
    parameter int LOG2_H   = 10,
    parameter int LOG2_W   = 10,
    parameter int LOG2_CH  = 12,
    parameter int LOG2_K   = 4,
    parameter int LOG2_S   = 3,
    parameter int LOG2_P   = 3,
    parameter int LOG2_D   = 3,
    parameter int LOG2_TIN = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      dw_mode,
    input  logic [LOG2_P-1:0]         pad_up,
    input  logic [LOG2_P-1:0]         pad_left,
    input  logic [LOG2_S-1:0]         sx,
    input  logic [LOG2_S-1:0]         sy,
    input  logic [LOG2_D-1:0]         dx,
    input  logic [LOG2_D-1:0]         dy,
    input  logic [LOG2_K-1:0]         kx,
    input  logic [LOG2_K-1:0]         ky,
    input  logic [LOG2_H-1:0]         hin,
    input  logic [LOG2_W-1:0]         win,
    input  logic [LOG2_H-1:0]         hout,
    input  logic [LOG2_W-1:0]         wout,
    input  logic [LOG2_CH-LOG2_TIN-1:0] chin_div_tin,
    input  logic [LOG2_CH-LOG2_TIN-1:0] chout_div_tout,
    output logic                      busy,
    output logic                      done,
    output logic                      feat_vld,
    input  logic                      feat_rdy,
    output logic [LOG2_H:0]           feat_h,
    output logic [LOG2_W:0]           feat_w,
    output logic [LOG2_CH-1:0]        feat_ch,
    output logic                      feat_pad,
    output logic                      wout_first,
    output logic                      wout_last,
    output logic                      acc_last,
    output logic                      tile_last
);

    localparam int HW = LOG2_H + 1;
    localparam int WW = LOG2_W + 1;
    localparam int CW = LOG2_CH - LOG2_TIN;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic              dw_q;
    logic [LOG2_P-1:0] pad_up_q, pad_left_q;
    logic [LOG2_S-1:0] sx_q, sy_q;
    logic [LOG2_D-1:0] dx_q, dy_q;
    logic [LOG2_K-1:0] kx_q, ky_q;
    logic [LOG2_H-1:0] hin_q, hout_q;
    logic [LOG2_W-1:0] win_q, wout_q;
    logic [CW-1:0]     chin_q, chout_q;

    logic [CW-1:0]     ct, ci;
    logic [LOG2_H-1:0] oh;
    logic [LOG2_W-1:0] ow;
    logic [LOG2_K-1:0] ky_i, kx_i;

    // Partial coordinates: row = h_oh + h_ky, col = w_kx + w_ow, each advanced by an adder only
    logic [HW-1:0] h_oh, h_ky, h_sum;
    logic [WW-1:0] w_kx, w_ow, w_sum;

    // Set when start was accepted with an empty loop nest; gives one busy cycle before done
    logic skip_q;

    logic start_ok, cfg_zero, fire;
    logic ow_wrap, ci_wrap, kx_wrap, ky_wrap, oh_wrap, ct_wrap;
    logic c_ci, c_kx, c_ky, c_oh, last_beat;

    assign start_ok = (state == IDLE) && start;
    assign cfg_zero = (hout == '0) || (wout == '0) || (kx == '0) || (ky == '0) ||
                      (chin_div_tin == '0) || (chout_div_tout == '0);
    assign fire     = (state == RUN) && feat_rdy;

    assign ow_wrap   = (ow == wout_q - LOG2_W'(1));
    assign ci_wrap   = dw_q || (ci == chin_q - CW'(1));
    assign kx_wrap   = (kx_i == kx_q - LOG2_K'(1));
    assign ky_wrap   = (ky_i == ky_q - LOG2_K'(1));
    assign oh_wrap   = (oh == hout_q - LOG2_H'(1));
    assign ct_wrap   = (ct == chout_q - CW'(1));
    assign c_ci      = ow_wrap && ci_wrap;
    assign c_kx      = c_ci && kx_wrap;
    assign c_ky      = c_kx && ky_wrap;
    assign c_oh      = c_ky && oh_wrap;
    assign last_beat = c_oh && ct_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = cfg_zero ? DONE : RUN;
            RUN:  if (fire && last_beat) state_nxt = DONE;
            DONE: if (!skip_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Configuration latch and loop counters; every counter wraps to 0 on its own carry
    always_ff @(posedge clk) begin
        if (rst) begin
            dw_q <= 1'b0; pad_up_q <= '0; pad_left_q <= '0;
            sx_q <= '0; sy_q <= '0; dx_q <= '0; dy_q <= '0;
            kx_q <= '0; ky_q <= '0; hin_q <= '0; win_q <= '0;
            hout_q <= '0; wout_q <= '0; chin_q <= '0; chout_q <= '0;
            ct <= '0; oh <= '0; ky_i <= '0; kx_i <= '0; ci <= '0; ow <= '0;
            h_oh <= '0; h_ky <= '0; w_kx <= '0; w_ow <= '0;
            skip_q <= 1'b0;
        end else if (start_ok) begin
            dw_q <= dw_mode; pad_up_q <= pad_up; pad_left_q <= pad_left;
            sx_q <= sx; sy_q <= sy; dx_q <= dx; dy_q <= dy;
            kx_q <= kx; ky_q <= ky; hin_q <= hin; win_q <= win;
            hout_q <= hout; wout_q <= wout; chin_q <= chin_div_tin; chout_q <= chout_div_tout;
            ct <= '0; oh <= '0; ky_i <= '0; kx_i <= '0; ci <= '0; ow <= '0;
            h_oh <= '0 - HW'(pad_up);
            h_ky <= '0;
            w_kx <= '0 - WW'(pad_left);
            w_ow <= '0;
            skip_q <= cfg_zero;
        end else begin
            if (state == DONE) skip_q <= 1'b0;
            if (fire) begin
                if (ow_wrap) begin
                    ow <= '0; w_ow <= '0;
                end else begin
                    ow <= ow + LOG2_W'(1); w_ow <= w_ow + WW'(sx_q);
                end
                if (ow_wrap && !dw_q) ci <= ci_wrap ? '0 : ci + CW'(1);
                if (c_ci) begin
                    if (kx_wrap) begin
                        kx_i <= '0; w_kx <= '0 - WW'(pad_left_q);
                    end else begin
                        kx_i <= kx_i + LOG2_K'(1); w_kx <= w_kx + WW'(dx_q);
                    end
                end
                if (c_kx) begin
                    if (ky_wrap) begin
                        ky_i <= '0; h_ky <= '0;
                    end else begin
                        ky_i <= ky_i + LOG2_K'(1); h_ky <= h_ky + HW'(dy_q);
                    end
                end
                if (c_ky) begin
                    if (oh_wrap) begin
                        oh <= '0; h_oh <= '0 - HW'(pad_up_q);
                    end else begin
                        oh <= oh + LOG2_H'(1); h_oh <= h_oh + HW'(sy_q);
                    end
                end
                if (c_oh) ct <= ct_wrap ? '0 : ct + CW'(1);
            end
        end
    end

    assign h_sum = h_oh + h_ky;
    assign w_sum = w_kx + w_ow;

    // Beat outputs are forced to zero outside RUN so idle and reset present a clean bus
    always_comb begin
        busy       = (state == RUN) || ((state == DONE) && skip_q);
        done       = (state == DONE) && !skip_q;
        feat_vld   = (state == RUN);
        feat_h     = '0;
        feat_w     = '0;
        feat_ch    = '0;
        feat_pad   = 1'b0;
        wout_first = 1'b0;
        wout_last  = 1'b0;
        acc_last   = 1'b0;
        tile_last  = 1'b0;
        if (state == RUN) begin
            feat_h     = h_sum;
            feat_w     = w_sum;
            feat_ch    = {(dw_q ? ct : ci), {LOG2_TIN{1'b0}}};
            feat_pad   = h_sum[HW-1] || (h_sum >= {1'b0, hin_q}) ||
                         w_sum[WW-1] || (w_sum >= {1'b0, win_q});
            wout_first = (ow == '0);
            wout_last  = ow_wrap;
            acc_last   = ky_wrap && kx_wrap && ci_wrap;
            tile_last  = c_oh;
        end
    end

endmodule

// File: tb/tb_conv_addr_gen.sv
// Self-checking bench for conv_addr_gen: a reference loop model fills a beat scoreboard at
// start, and each handshaked beat is popped and compared.
module tb_conv_addr_gen;

    logic              clk = 1'b0;
    logic              rst, start, dw_mode, feat_rdy;
    logic [2:0]        pad_up, pad_left, sx, sy, dx, dy;
    logic [3:0]        kx, ky;
    logic [9:0]        hin, win, hout, wout;
    logic [6:0]        chin_div_tin, chout_div_tout;
    logic              busy, done, feat_vld, feat_pad;
    logic              wout_first, wout_last, acc_last, tile_last;
    logic [10:0]       feat_h, feat_w;
    logic [11:0]       feat_ch;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] w;
        logic [11:0] ch;
        logic        pad;
        logic        first;
        logic        last;
        logic        acc;
        logic        tile;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;

    conv_addr_gen dut (
        .clk(clk), .rst(rst), .start(start), .dw_mode(dw_mode),
        .pad_up(pad_up), .pad_left(pad_left), .sx(sx), .sy(sy), .dx(dx), .dy(dy),
        .kx(kx), .ky(ky), .hin(hin), .win(win), .hout(hout), .wout(wout),
        .chin_div_tin(chin_div_tin), .chout_div_tout(chout_div_tout),
        .busy(busy), .done(done), .feat_vld(feat_vld), .feat_rdy(feat_rdy),
        .feat_h(feat_h), .feat_w(feat_w), .feat_ch(feat_ch), .feat_pad(feat_pad),
        .wout_first(wout_first), .wout_last(wout_last), .acc_last(acc_last),
        .tile_last(tile_last)
    );

    always #5 clk = ~clk;

    function automatic beat_t curBeat();
        return {feat_h, feat_w, feat_ch, feat_pad, wout_first, wout_last, acc_last, tile_last};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: direct multiply-based coordinates in loop order
    task automatic buildExpected();
        beat_t b;
        int    nci, h, w;
        exp_q.delete();
        nci = dw_mode ? 1 : int'(chin_div_tin);
        for (int ct = 0; ct < int'(chout_div_tout); ct++)
            for (int oh = 0; oh < int'(hout); oh++)
                for (int yi = 0; yi < int'(ky); yi++)
                    for (int xi = 0; xi < int'(kx); xi++)
                        for (int ci = 0; ci < nci; ci++)
                            for (int ow = 0; ow < int'(wout); ow++) begin
                                h = oh * int'(sy) + yi * int'(dy) - int'(pad_up);
                                w = ow * int'(sx) + xi * int'(dx) - int'(pad_left);
                                b.h     = 11'(h);
                                b.w     = 11'(w);
                                b.ch    = 12'((dw_mode ? ct : ci) * 32);
                                b.pad   = (h < 0) || (h >= int'(hin)) || (w < 0) || (w >= int'(win));
                                b.first = (ow == 0);
                                b.last  = (ow == int'(wout) - 1);
                                b.acc   = (yi == int'(ky) - 1) && (xi == int'(kx) - 1) && (ci == nci - 1);
                                b.tile  = b.acc && (oh == int'(hout) - 1) && (ow == int'(wout) - 1);
                                exp_q.push_back(b);
                            end
    endtask

    task automatic setLoopCfg();
        dw_mode = 0; kx = 3; ky = 3; sx = 1; sy = 1; dx = 1; dy = 1;
        pad_up = 1; pad_left = 1; hin = 4; win = 4; hout = 4; wout = 4;
        chin_div_tin = 1; chout_div_tout = 1;
    endtask

    task automatic applyStimulus(input bit scramble);
        buildExpected();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        if (scramble) begin
            kx = 0; hout = 0; sx = 5; pad_left = 7; win = 1;
        end
        checkOutput("start_busy", busy, 1);
        checkOutput("start_vld", feat_vld, exp_q.size() > 0);
    endtask

    task automatic runWalk(input int rdy_pct, input int stop_after);
        int    hs = 0;
        int    cycles = 0;
        bit    stalled = 0;
        beat_t held, e;
        while (exp_q.size() > 0 && cycles < 5000 && (stop_after < 0 || hs < stop_after)) begin
            @(negedge clk);
            cycles++;
            if (stalled) begin
                checkOutput("stall_vld", feat_vld, 1);
                checkOutput("stall_hold", curBeat(), held);
            end
            checkOutput("no_early_done", done, 0);
            feat_rdy = ($urandom_range(0, 99) < rdy_pct);
            stalled = 0;
            if (feat_vld) begin
                if (feat_rdy) begin
                    e = exp_q.pop_front();
                    checkOutput($sformatf("beat%0d", hs), curBeat(), e);
                    hs++;
                end else begin
                    stalled = 1;
                    held = curBeat();
                end
            end
        end
        if (stop_after < 0) begin
            checkOutput("walk_timeout", exp_q.size(), 0);
            @(negedge clk);
            feat_rdy = 0;
            checkOutput("done_pulse", done, 1);
            checkOutput("done_busy_low", busy, 0);
            checkOutput("done_vld_low", feat_vld, 0);
            @(negedge clk);
            checkOutput("done_one_cycle", done, 0);
            checkOutput("idle_busy", busy, 0);
        end
    endtask

    initial begin
        rst = 1; start = 0; feat_rdy = 0;
        setLoopCfg();
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_vld", feat_vld, 0);
        checkOutput("rst_beat", curBeat(), 0);
        rst = 0;

        $display("[TB] loop order, full rate");
        setLoopCfg();
        applyStimulus(0);
        runWalk(100, -1);

        $display("[TB] dilation and stride");
        setLoopCfg();
        kx = 3; dx = 2; sx = 2; wout = 3; pad_up = 0; pad_left = 0; ky = 1; win = 9; hout = 1;
        applyStimulus(0);
        runWalk(100, -1);

        $display("[TB] depthwise");
        setLoopCfg();
        dw_mode = 1; chout_div_tout = 2; chin_div_tin = 2; kx = 1; ky = 1;
        hout = 1; wout = 1; hin = 1; win = 1; pad_up = 0; pad_left = 0;
        applyStimulus(0);
        runWalk(100, -1);

        $display("[TB] backpressure with config changes during run");
        setLoopCfg();
        applyStimulus(1);
        runWalk(30, -1);

        $display("[TB] degenerate hout=0");
        setLoopCfg();
        hout = 0;
        applyStimulus(0);
        @(negedge clk);
        checkOutput("degen_done", done, 1);
        checkOutput("degen_busy_low", busy, 0);
        checkOutput("degen_vld", feat_vld, 0);
        @(negedge clk);
        checkOutput("degen_done_low", done, 0);
        checkOutput("degen_vld_after", feat_vld, 0);

        $display("[TB] reset mid-run");
        setLoopCfg();
        applyStimulus(0);
        runWalk(100, 50);
        feat_rdy = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        checkOutput("midrst_vld", feat_vld, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_beat", curBeat(), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_done", done, 0);
        end
        setLoopCfg();
        applyStimulus(0);
        runWalk(100, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
